// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone slave modelling a word-organised SRAM with
// programmable wait states and incrementing bursts (bl/bry handshake).
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   wbd_dat_i[31:0]   write data
//   wbd_adr_i[31:0]   byte address ([1:0] ignored)
//   wbd_sel_i[3:0]    byte enables
//   wbd_bl_i[9:0]     burst length in beats (0 means 1)
//   wbd_bry_i         master ready for next burst beat
//   wbd_we_i          1 write, 0 read (latched per transaction)
//   wbd_cyc_i         bus cycle active
//   wbd_stb_i         request strobe
//   wbd_dat_o[31:0]   read data, 0 when no ack
//   wbd_ack_o         one-cycle beat acknowledge
//   wbd_err_o         error terminate (only with WB_RESP_ERR_EN)
//
// Optional feature macro: WB_RESP_ERR_EN
//   defined   - out-of-range beat raises err_o and ends the transaction
//   undefined - out-of-range beat acks, reads 0, drops writes

module wb_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] wbd_dat_i,
   input  logic [31:0] wbd_adr_i,
   input  logic [3:0]  wbd_sel_i,
   input  logic [9:0]  wbd_bl_i,
   input  logic        wbd_bry_i,
   input  logic        wbd_we_i,
   input  logic        wbd_cyc_i,
   input  logic        wbd_stb_i,
   output logic [31:0] wbd_dat_o,
   output logic        wbd_ack_o
`ifdef WB_RESP_ERR_EN
   ,
   output logic        wbd_err_o
`endif
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_BEAT,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_adr;
   logic [31:0] w_adr_nxt;
   logic        r_we;
   logic        w_we_nxt;
   logic [9:0]  r_left;
   logic [9:0]  w_left_nxt;
   logic [3:0]  r_wcnt;
   logic [3:0]  w_wcnt_nxt;
   logic        r_first;
   logic        w_first_nxt;

   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_req;
   logic          w_borrow;
   logic [31:0]   w_off;
   logic          w_inrng;
   logic [AW-1:0] w_idx;
   logic          w_fire;
   logic          w_ack;
   logic          w_err;
   logic          w_wr;
   logic          w_unused;

   assign w_req = wbd_cyc_i & wbd_stb_i;

   // The borrow of the subtraction flags addresses below the window
   // without a constant comparison when BASE_ADDR is zero.
   assign {w_borrow, w_off} = {1'b0, r_adr} - {1'b0, BASE_ADDR};
   assign w_inrng  = ~w_borrow & (w_off[31:AW+2] == '0);
   assign w_idx    = w_off[AW+1:2];
   assign w_unused = &{1'b0, w_off[1:0]};

   // A beat completes when the request is still held and the master is
   // ready; the first beat does not wait for bry. Abort wins over bry.
   assign w_fire = (r_state == S_BEAT) & w_req & (r_first | wbd_bry_i);

`ifdef WB_RESP_ERR_EN
   assign w_ack     = w_fire & w_inrng;
   assign w_err     = w_fire & ~w_inrng;
   assign wbd_err_o = w_err;
`else
   assign w_ack = w_fire;
   assign w_err = 1'b0;
`endif

   assign wbd_ack_o = w_ack;
   assign wbd_dat_o = (w_ack & ~r_we & w_inrng) ? r_mem[w_idx] : 32'h0;
   assign w_wr      = w_ack & r_we & w_inrng;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_adr   <= '0;
         r_we    <= 1'b0;
         r_left  <= '0;
         r_wcnt  <= '0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_adr   <= w_adr_nxt;
         r_we    <= w_we_nxt;
         r_left  <= w_left_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_first <= w_first_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_adr_nxt   = r_adr;
      w_we_nxt    = r_we;
      w_left_nxt  = r_left;
      w_wcnt_nxt  = r_wcnt;
      w_first_nxt = r_first;
      unique case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_adr_nxt   = wbd_adr_i;
               w_we_nxt    = wbd_we_i;
               w_left_nxt  = (wbd_bl_i == 10'd0) ? 10'd1 : wbd_bl_i;
               w_first_nxt = 1'b1;
               if (WAIT_STATES != 0) begin
                  w_state_nxt = S_WAIT;
                  w_wcnt_nxt  = 4'(WAIT_STATES - 1);
               end else begin
                  w_state_nxt = S_BEAT;
               end
            end
         end
         S_WAIT: begin
            if (!w_req) begin
               w_state_nxt = S_IDLE;
            end else if (r_wcnt == 4'd0) begin
               w_state_nxt = S_BEAT;
            end else begin
               w_wcnt_nxt = r_wcnt - 4'd1;
            end
         end
         S_BEAT: begin
            if (!w_req) begin
               w_state_nxt = S_IDLE;
            end else if (w_err) begin
               w_first_nxt = 1'b0;
               w_state_nxt = S_DONE;
            end else if (w_ack) begin
               w_first_nxt = 1'b0;
               w_left_nxt  = r_left - 10'd1;
               if (r_left == 10'd1) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_adr_nxt = r_adr + 32'd4;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Memory has no reset: contents survive reset_n.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (wbd_sel_i[i]) begin
               r_mem[w_idx][8*i +: 8] <= wbd_dat_i[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_mem_responder.sv
// tb_wb_mem_responder: directed plus random transactions against a
// word-array reference model of the Wishbone memory responder.

module tb_wb_mem_responder;

   localparam int WS    = 1;
   localparam int DEPTH = 256;

   logic        clk;
   logic        reset_n;
   logic [31:0] wbd_dat_i;
   logic [31:0] wbd_adr_i;
   logic [3:0]  wbd_sel_i;
   logic [9:0]  wbd_bl_i;
   logic        wbd_bry_i;
   logic        wbd_we_i;
   logic        wbd_cyc_i;
   logic        wbd_stb_i;
   logic [31:0] wbd_dat_o;
   logic        wbd_ack_o;
`ifdef WB_RESP_ERR_EN
   logic        wbd_err_o;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int g_acks;
   int g_errs;
   logic [31:0] last_rd;
   logic [31:0] mdl [DEPTH];

   wb_mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(WS),
      .BASE_ADDR(32'h0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .wbd_dat_i(wbd_dat_i),
      .wbd_adr_i(wbd_adr_i),
      .wbd_sel_i(wbd_sel_i),
      .wbd_bl_i(wbd_bl_i),
      .wbd_bry_i(wbd_bry_i),
      .wbd_we_i(wbd_we_i),
      .wbd_cyc_i(wbd_cyc_i),
      .wbd_stb_i(wbd_stb_i),
      .wbd_dat_o(wbd_dat_o),
      .wbd_ack_o(wbd_ack_o)
`ifdef WB_RESP_ERR_EN
      ,
      .wbd_err_o(wbd_err_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction, cycle by cycle. Expectations come from the bus
   // rules: WS idle cycles, then one beat per bry-high cycle, address
   // +4 per beat, out-of-range beats read 0 / drop writes (or error).
   task automatic xfer(input logic [31:0] adr, input logic we,
                       input int bl, input logic [3:0] sel,
                       input int stall_at, input int stall_n,
                       input bit use_fix, input logic [31:0] wfix);
      int nb;
      int b;
      int c;
      int st;
      bit done;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] ed;
      logic ea;
      logic ee;
      logic inr;
      nb = (bl == 0) ? 1 : bl;
      b = 0;
      c = 0;
      st = 0;
      done = 0;
      g_acks = 0;
      g_errs = 0;
      wbd_adr_i = adr;
      wbd_we_i  = we;
      wbd_bl_i  = bl[9:0];
      wbd_sel_i = sel;
      wbd_cyc_i = 1'b1;
      wbd_stb_i = 1'b1;
      wbd_bry_i = 1'b1;
      @(posedge clk);
      #1;
      while (!done && c < 600) begin
         c++;
         wbd_bry_i = !(c > WS && b == stall_at && b > 0 &&
                       st < stall_n);
         wd = use_fix ? wfix + 32'(b) : $urandom;
         wbd_dat_i = wd;
         a = adr + 32'(4 * b);
         inr = (a >> 2) < DEPTH;
         ea = (c > WS) && (b == 0 || wbd_bry_i);
`ifdef WB_RESP_ERR_EN
         ee = ea && !inr;
         ea = ea && inr;
`else
         ee = 1'b0;
`endif
         ed = (ea && !we && inr) ? mdl[a[9:2]] : 32'h0;
         @(negedge clk);
         chk("ack", {31'b0, wbd_ack_o}, {31'b0, ea});
         chk("dat", wbd_dat_o, ed);
`ifdef WB_RESP_ERR_EN
         chk("err", {31'b0, wbd_err_o}, {31'b0, ee});
`endif
         if (wbd_ack_o && !we) last_rd = wbd_dat_o;
         if (!ea && !ee && c > WS) st++;
         if (ea && we && inr) begin
            for (int i = 0; i < 4; i++) begin
               if (sel[i]) mdl[a[9:2]][8*i +: 8] = wd[8*i +: 8];
            end
         end
         if (wbd_ack_o) g_acks++;
`ifdef WB_RESP_ERR_EN
         if (wbd_err_o) g_errs++;
`endif
         if (ea || ee) begin
            b++;
            if (ee || b == nb) done = 1;
         end
         @(posedge clk);
         #1;
      end
      chk("timeout", {31'b0, done}, 32'd1);
      wbd_cyc_i = 1'b0;
      wbd_stb_i = 1'b0;
      wbd_bry_i = 1'b1;
      @(negedge clk);
      chk("done_ack", {31'b0, wbd_ack_o}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] old30;
      reset_n   = 1'b0;
      wbd_dat_i = '0;
      wbd_adr_i = '0;
      wbd_sel_i = '0;
      wbd_bl_i  = '0;
      wbd_bry_i = 1'b1;
      wbd_we_i  = 1'b0;
      wbd_cyc_i = 1'b0;
      wbd_stb_i = 1'b0;
      last_rd   = '0;
      #2;
      chk("rst_ack", {31'b0, wbd_ack_o}, 32'd0);
      chk("rst_dat", wbd_dat_o, 32'h0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // preload the whole array so every read has a known value
      xfer(32'h0, 1'b1, DEPTH, 4'hF, 0, 0, 1'b0, 32'h0);
      chk("preload_acks", g_acks, DEPTH);

      // basic write / read with wait-state latency
      xfer(32'h10, 1'b1, 1, 4'hF, 0, 0, 1'b1, 32'hDEADBEEF);
      xfer(32'h10, 1'b0, 1, 4'hF, 0, 0, 1'b0, 32'h0);
      chk("rd_10", last_rd, 32'hDEADBEEF);

      // byte lanes
      xfer(32'h20, 1'b1, 1, 4'hF, 0, 0, 1'b1, 32'hFFFFFFFF);
      xfer(32'h20, 1'b1, 1, 4'b0101, 0, 0, 1'b1, 32'h0);
      xfer(32'h20, 1'b0, 1, 4'hF, 0, 0, 1'b0, 32'h0);
      chk("lanes", last_rd, 32'hFF00FF00);

      // burst with a 2-cycle stall on the third beat
      xfer(32'h40, 1'b1, 4, 4'hF, 0, 0, 1'b1, 32'd1);
      xfer(32'h40, 1'b0, 4, 4'hF, 2, 2, 1'b0, 32'h0);
      chk("burst_acks", g_acks, 4);
      chk("burst_last", last_rd, 32'd4);
      xfer(32'h44, 1'b0, 0, 4'hF, 0, 0, 1'b0, 32'h0);
      chk("bl0_acks", g_acks, 1);
      chk("bl0_dat", last_rd, 32'd2);

      // abort in WAIT: no ack, memory untouched
      old30 = mdl[12];
      wbd_adr_i = 32'h30;
      wbd_we_i  = 1'b1;
      wbd_bl_i  = 10'd1;
      wbd_sel_i = 4'hF;
      wbd_dat_i = ~old30;
      wbd_cyc_i = 1'b1;
      wbd_stb_i = 1'b1;
      @(posedge clk);
      #1 wbd_stb_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_ack", {31'b0, wbd_ack_o}, 32'd0);
         @(posedge clk);
         #1;
      end
      wbd_cyc_i = 1'b0;
      xfer(32'h30, 1'b0, 1, 4'hF, 0, 0, 1'b0, 32'h0);
      chk("abort_mem", last_rd, old30);

      // out of range
      xfer(32'h400, 1'b0, 1, 4'hF, 0, 0, 1'b0, 32'h0);
`ifdef WB_RESP_ERR_EN
      chk("oor_err", g_errs, 1);
      chk("oor_acks", g_acks, 0);
`else
      chk("oor_acks", g_acks, 1);
      chk("oor_dat", last_rd, 32'h0);
`endif
      xfer(32'h3F8, 1'b0, 4, 4'hF, 0, 0, 1'b0, 32'h0);
`ifdef WB_RESP_ERR_EN
      chk("oorb_acks", g_acks, 2);
      chk("oorb_err", g_errs, 1);
`else
      chk("oorb_acks", g_acks, 4);
`endif
      xfer(32'h3FC, 1'b1, 2, 4'hF, 0, 0, 1'b0, 32'h0);

      // random traffic
      for (int t = 0; t < 40; t++) begin
         logic [31:0] ra;
         ra = 32'($urandom_range(0, DEPTH - 1)) * 4 +
              32'($urandom_range(0, 3));
         xfer(ra, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
              4'($urandom_range(0, 15)), $urandom_range(1, 3),
              $urandom_range(0, 2), 1'b0, 32'h0);
      end

      // async reset mid-burst
      wbd_adr_i = 32'h0;
      wbd_we_i  = 1'b0;
      wbd_bl_i  = 10'd8;
      wbd_sel_i = 4'hF;
      wbd_bry_i = 1'b1;
      wbd_cyc_i = 1'b1;
      wbd_stb_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_ack", {31'b0, wbd_ack_o}, 32'd1);
      chk("pre_rst_dat", wbd_dat_o, mdl[0]);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_ack", {31'b0, wbd_ack_o}, 32'd0);
      chk("mid_rst_dat", wbd_dat_o, 32'h0);
      wbd_cyc_i = 1'b0;
      wbd_stb_i = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      xfer(32'h20, 1'b0, 1, 4'hF, 0, 0, 1'b0, 32'h0);
      chk("post_rst_20", last_rd, mdl[8]);
      xfer(32'h10, 1'b0, 4, 4'hF, 1, 1, 1'b0, 32'h0);
      chk("post_rst_acks", g_acks, 4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
